// File: rtl/rns_conv_sched_pkg.sv
// Shared constants and entry types for the 32/31/21/5 residue number system scheduler.
// Widths here fix the operand, residue and result-entry layouts used across the block.
package rns_32_31_21_5_pkg;

  localparam int MOD_1 = 32;
  localparam int MOD_2 = 31;
  localparam int MOD_3 = 21;
  localparam int MOD_4 = 5;
  localparam int RNS_M = MOD_1 * MOD_2 * MOD_3 * MOD_4;

  localparam int DYN_SIZE = 16;
  localparam int MAX_MOD  = 5;
  localparam int OP_W     = DYN_SIZE + 1;
  // Wide enough for the largest supported requester count (8).
  localparam int ID_W     = 3;

  typedef logic [OP_W-1:0] operand_t;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [MAX_MOD-1:0] res1;
    logic [MAX_MOD-1:0] res2;
    logic [MAX_MOD-1:0] res3;
    logic [MAX_MOD-1:0] res4;
    logic               err;
  } res_entry_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            err;
  } tag_t;

  function automatic logic out_of_range(input operand_t n);
    return n >= OP_W'(RNS_M);
  endfunction

endpackage

// File: rtl/rns_conv_sched_if.sv
// Requester, converter and result-side signals of the scheduler; master is the scheduler side.
// out_err exists only when RNS_RANGE_CHECK_EN is defined.
interface rns_conv_sched_if
  import rns_32_31_21_5_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*OP_W-1:0] req_data;

  logic [OP_W-1:0]    conv_n;
  logic [MAX_MOD-1:0] conv_res_1;
  logic [MAX_MOD-1:0] conv_res_2;
  logic [MAX_MOD-1:0] conv_res_3;
  logic [MAX_MOD-1:0] conv_res_4;

  logic               out_valid;
  logic               out_ready;
  logic [IW-1:0]      out_id;
  logic [MAX_MOD-1:0] out_res_1;
  logic [MAX_MOD-1:0] out_res_2;
  logic [MAX_MOD-1:0] out_res_3;
  logic [MAX_MOD-1:0] out_res_4;
  logic               busy;
`ifdef RNS_RANGE_CHECK_EN
  logic               out_err;
`endif

  modport master (
`ifdef RNS_RANGE_CHECK_EN
    output out_err,
`endif
    input  req_valid, req_data,
    output req_ready,
    output conv_n,
    input  conv_res_1, conv_res_2, conv_res_3, conv_res_4,
    output out_valid, out_id, out_res_1, out_res_2, out_res_3, out_res_4,
    input  out_ready,
    output busy
  );

  modport slave (
`ifdef RNS_RANGE_CHECK_EN
    input  out_err,
`endif
    output req_valid, req_data,
    input  req_ready,
    input  conv_n,
    output conv_res_1, conv_res_2, conv_res_3, conv_res_4,
    input  out_valid, out_id, out_res_1, out_res_2, out_res_3, out_res_4,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/rns_conv_sched_result_fifo.sv
// Synchronous result FIFO with occupancy count; head is combinational, reads zero when empty.
// One-cycle push-to-visible; pushes while full are dropped (upstream credits prevent them).
module rns_result_fifo
  import rns_32_31_21_5_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  res_entry_t    push_dat_i,
  input  logic          pop_i,
  output res_entry_t    head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  res_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (cnt_q != CW'(DEPTH));

  // Power-of-two depth lets the pointers wrap on their own.
  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_dat_i;
    end
  end

  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/rns_conv_sched.sv
// Round-robin, credit-gated sharing of one pipelined binary-to-RNS converter; results in issue order.
// Latency CONV_LAT+1 operand to out_valid; RNS_RANGE_CHECK_EN adds a per-result out-of-range flag.
module rns_conv_sched
  import rns_32_31_21_5_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int CONV_LAT   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  rns_conv_sched_if.master bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [IW-1:0]      ptr_q, ptr_d;
  operand_t           conv_n_q, conv_n_d;
  tag_t               tag_q [CONV_LAT];
  tag_t               tag_in;
  logic               credit_ok;
  logic               gnt_vld;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      cand;
  logic [NUM_REQ-1:0] ready;
  operand_t           gnt_dat;
  logic [3:0]         inflight_cnt;
  logic [CW-1:0]      fifo_cnt;
  logic               fifo_empty;
  logic               push, pop;
  res_entry_t         push_dat, head;
  logic               unused_head;

  always_comb begin
    inflight_cnt = '0;
    for (int s = 0; s < CONV_LAT; s++) begin
      inflight_cnt = inflight_cnt + 4'(tag_q[s].vld);
    end
  end

  // A pop only frees its slot once fifo_cnt has updated, i.e. from the next cycle.
  assign credit_ok = (32'(fifo_cnt) + 32'(inflight_cnt)) < 32'(FIFO_DEPTH);

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((32'(ptr_q) + 32'(i)) % 32'(NUM_REQ));
      if (!gnt_vld && credit_ok && bus.req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) begin
      ready[gnt_idx] = 1'b1;
    end
  end

  assign gnt_dat = bus.req_data[gnt_idx*OP_W +: OP_W];

  always_comb begin
    ptr_d    = ptr_q;
    conv_n_d = conv_n_q;
    tag_in   = '0;
    if (gnt_vld) begin
      ptr_d      = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      conv_n_d   = gnt_dat;
      tag_in.vld = 1'b1;
      tag_in.id  = ID_W'(gnt_idx);
`ifdef RNS_RANGE_CHECK_EN
      tag_in.err = out_of_range(gnt_dat);
`else
      tag_in.err = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      conv_n_q <= '0;
      for (int s = 0; s < CONV_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      conv_n_q <= conv_n_d;
      tag_q[0] <= tag_in;
      for (int s = 1; s < CONV_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // The last tag stage lines up with the residues of the operand it describes.
  always_comb begin
    push_dat      = '0;
    push_dat.id   = tag_q[CONV_LAT-1].id;
    push_dat.res1 = bus.conv_res_1;
    push_dat.res2 = bus.conv_res_2;
    push_dat.res3 = bus.conv_res_3;
    push_dat.res4 = bus.conv_res_4;
    push_dat.err  = tag_q[CONV_LAT-1].err;
  end

  assign push = tag_q[CONV_LAT-1].vld;
  assign pop  = !fifo_empty && bus.out_ready;

  rns_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  assign bus.req_ready = ready;
  assign bus.conv_n    = conv_n_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_id    = head.id[IW-1:0];
  assign bus.out_res_1 = head.res1;
  assign bus.out_res_2 = head.res2;
  assign bus.out_res_3 = head.res3;
  assign bus.out_res_4 = head.res4;
  assign bus.busy      = (inflight_cnt != '0) || (fifo_cnt != '0);
`ifdef RNS_RANGE_CHECK_EN
  assign bus.out_err   = head.err;
`endif

  assign unused_head = &{1'b0, head.id, head.err};

endmodule
